// File: rtl/spi_master_if.sv
// Bus bundle between a host controller and the SPI mode-0 master:
// word handshake, captured-word strobe, status and the four SPI pins.
interface spi_master_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, sck, cs_n, mosi
  );

  modport slave (
    output tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, sck, cs_n, mosi
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: one MSB-first word per cs_n frame, full duplex capture.
//   state  | meaning
//   IDLE   | cs_n high, tx_ready high, waiting for a word
//   SETUP  | cs_n low, sck low, first bit on mosi before the first rise
//   SCK_HI | sck high half-period
//   SCK_LO | sck low half-period, next bit on mosi
//   HOLD   | sck low after the last fall, cs_n still low
//   GAP    | cs_n high recovery before accepting the next word
module spi_master #(
  parameter int WORD_W   = 16,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam int MAX_A = (CLK_DIV  > CS_SETUP) ? CLK_DIV  : CS_SETUP;
  localparam int MAX_B = (CS_HOLD  > CS_GAP)   ? CS_HOLD  : CS_GAP;
  localparam int MAX_C = (MAX_A    > MAX_B)    ? MAX_A    : MAX_B;
  localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [WORD_W-1:0] tx_sh, tx_sh_nxt;
  logic [WORD_W-1:0] rx_sh, rx_sh_nxt;
  logic [WORD_W-1:0] rx_data_q, rx_data_nxt;
  logic              rx_valid_q, rx_valid_nxt;
  logic              sck_q, sck_nxt;
  logic              cs_n_q, cs_n_nxt;
  logic              busy_q, busy_nxt;
  logic              tx_ready_q, tx_ready_nxt;
  logic              last, accept;

  assign last   = (cnt == '0);
  assign accept = bus.tx_valid & tx_ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (last)   state_nxt = SCK_HI;
      SCK_HI:  if (last)   state_nxt = (bit_cnt == LAST_BIT) ? HOLD : SCK_LO;
      SCK_LO:  if (last)   state_nxt = SCK_HI;
      HOLD:    if (last)   state_nxt = GAP;
      GAP:     if (last)   state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    cnt_nxt      = last ? cnt : cnt - CNT_W'(1);
    bit_cnt_nxt  = bit_cnt;
    tx_sh_nxt    = tx_sh;
    rx_sh_nxt    = rx_sh;
    rx_data_nxt  = rx_data_q;
    rx_valid_nxt = 1'b0;
    sck_nxt      = sck_q;
    cs_n_nxt     = cs_n_q;
    case (state)
      IDLE: begin
        if (accept) begin
          tx_sh_nxt   = bus.tx_data;
          cs_n_nxt    = 1'b0;
          sck_nxt     = 1'b0;
          bit_cnt_nxt = 4'd0;
          cnt_nxt     = CNT_W'(CS_SETUP - 1);
        end
      end
      SETUP, SCK_LO: begin
        // miso is captured in the cycle right before each sck rise
        if (last) begin
          rx_sh_nxt = {rx_sh[WORD_W-2:0], bus.miso};
          sck_nxt   = 1'b1;
          cnt_nxt   = CNT_W'(CLK_DIV - 1);
        end
      end
      SCK_HI: begin
        if (last) begin
          sck_nxt = 1'b0;
          if (bit_cnt == LAST_BIT) begin
            cnt_nxt = CNT_W'(CS_HOLD - 1);
          end else begin
            tx_sh_nxt   = {tx_sh[WORD_W-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 4'd1;
            cnt_nxt     = CNT_W'(CLK_DIV - 1);
          end
        end
      end
      HOLD: begin
        if (last) begin
          cs_n_nxt     = 1'b1;
          tx_sh_nxt    = '0;
          rx_data_nxt  = rx_sh;
          rx_valid_nxt = 1'b1;
          cnt_nxt      = CNT_W'(CS_GAP - 1);
        end
      end
      default: ;
    endcase
    tx_ready_nxt = (state_nxt == IDLE);
    busy_nxt     = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_cnt    <= 4'd0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      tx_sh      <= tx_sh_nxt;
      rx_sh      <= rx_sh_nxt;
      rx_data_q  <= rx_data_nxt;
      rx_valid_q <= rx_valid_nxt;
      sck_q      <= sck_nxt;
      cs_n_q     <= cs_n_nxt;
      busy_q     <= busy_nxt;
      tx_ready_q <= tx_ready_nxt;
    end
  end

  // mosi is the shifter MSB; the shifter is cleared when the frame closes
  assign bus.mosi     = tx_sh[WORD_W-1];
  assign bus.sck      = sck_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.tx_ready = tx_ready_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, slave model, tied miso,
// back-to-back framing, mid-frame reset and a CLK_DIV=4 instance.
module tb_spi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if m ();
  spi_master_if m4 ();

  int miso_mode = 2;  // 0: tied 0, 1: tied 1, 2: loopback
  assign m.miso  = (miso_mode == 2) ? m.mosi : (miso_mode == 1);
  assign m4.miso = m4.mosi;

  spi_master dut (.clk(clk), .rst_n(rst_n), .bus(m));
  spi_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(m4));

  int total = 0;
  int bad   = 0;

  // Frame monitor for the default instance, sampled on the falling edge.
  int          rises = 0, rxv = 0;
  int          lo_run = 0, hi_run = 0, last_lo_run = 0, last_hi_run = 0;
  logic [15:0] mosi_cap = '0;
  logic        sck_p = 1'b0, cs_p = 1'b1;
  always @(negedge clk) begin
    if (m.sck === 1'b1 && sck_p === 1'b0) begin
      rises++;
      mosi_cap = {mosi_cap[14:0], m.mosi};
    end
    sck_p = m.sck;
    if (m.cs_n === 1'b0) begin
      if (cs_p === 1'b1) last_hi_run = hi_run;
      lo_run++;
      hi_run = 0;
    end else begin
      if (cs_p === 1'b0) last_lo_run = lo_run;
      hi_run++;
      lo_run = 0;
    end
    cs_p = m.cs_n;
    if (m.rx_valid === 1'b1) rxv++;
  end

  // Monitor for the CLK_DIV=4 instance.
  int   rises4 = 0, lo4 = 0, last_lo4_cs = 0;
  int   shi4 = 0, slo4 = 0, last_shi4 = 0, last_slo4 = 0;
  logic sck4_p = 1'b0, cs4_p = 1'b1;
  always @(negedge clk) begin
    if (m4.sck === 1'b1) begin
      if (sck4_p === 1'b0) begin
        rises4++;
        last_slo4 = slo4;
      end
      shi4++;
      slo4 = 0;
    end else begin
      if (sck4_p === 1'b1) last_shi4 = shi4;
      slo4++;
      shi4 = 0;
    end
    sck4_p = m4.sck;
    if (m4.cs_n === 1'b0) lo4++;
    else begin
      if (cs4_p === 1'b0) last_lo4_cs = lo4;
      lo4 = 0;
    end
    cs4_p = m4.cs_n;
  end

  // Behavioural SPI slave receiver: samples mosi on sck rise, delivers on cs_n rise.
  logic [15:0] sl_sh = '0, sl_data = '0;
  int          sl_bits = 0, sl_rxv = 0;
  always @(posedge m.sck or posedge m.cs_n) begin
    if (m.cs_n === 1'b1) begin
      if (sl_bits == 16) begin
        sl_data = sl_sh;
        sl_rxv++;
      end
      sl_bits = 0;
    end else begin
      sl_sh = {sl_sh[14:0], m.mosi};
      sl_bits++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 400 && m.tx_ready !== 1'b1; i++) @(negedge clk);
    chk(tag, m.tx_ready, 1);
  endtask

  task automatic wait_rx(input string tag);
    for (int i = 0; i < 400 && m.rx_valid !== 1'b1; i++) @(negedge clk);
    chk(tag, m.rx_valid, 1);
  endtask

  task automatic send(input logic [15:0] word, input string tag);
    m.tx_data  = word;
    m.tx_valid = 1'b1;
    wait_ready(tag);
    @(negedge clk);
    m.tx_valid = 1'b0;
  endtask

  int r0, v0, s0, n;
  logic sp;

  initial begin
    m.tx_valid = 1'b0;  m.tx_data = '0;
    m4.tx_valid = 1'b0; m4.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck", m.sck, 0);
    chk("rst_cs_n", m.cs_n, 1);
    chk("rst_mosi", m.mosi, 0);
    chk("rst_rx_valid", m.rx_valid, 0);
    chk("rst_busy", m.busy, 0);
    chk("rst_rx_data", m.rx_data, 0);
    chk("rst_tx_ready", m.tx_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_tx_ready", m.tx_ready, 1);

    // 1: loopback A5C3
    miso_mode = 2;
    r0 = rises; v0 = rxv;
    send(16'hA5C3, "t1_ready");
    chk("t1_cs_n_low", m.cs_n, 0);
    chk("t1_busy", m.busy, 1);
    chk("t1_tx_ready_low", m.tx_ready, 0);
    chk("t1_mosi_msb", m.mosi, 1);
    wait_rx("t1_rx_seen");
    chk("t1_rx_data", m.rx_data, 16'hA5C3);
    chk("t1_busy_in_gap", m.busy, 1);
    @(negedge clk);
    chk("t1_rx_valid_width", m.rx_valid, 0);
    chk("t1_rises", rises - r0, 16);
    chk("t1_cs_low", last_lo_run, 66);
    chk("t1_mosi_cap", mosi_cap, 16'hA5C3);
    chk("t1_rxv_count", rxv - v0, 1);
    wait_ready("t1_idle");
    chk("t1_idle_busy", m.busy, 0);

    // 2: slave model
    s0 = sl_rxv;
    send(16'h1234, "t2_ready");
    wait_rx("t2_rx_seen");
    @(negedge clk);
    chk("t2_slave_data", sl_data, 16'h1234);
    chk("t2_slave_rxv", sl_rxv - s0, 1);
    wait_ready("t2_idle");

    // 3: miso tied 1 then 0
    miso_mode = 1;
    send(16'h5A5A, "t3a_ready");
    wait_rx("t3a_rx_seen");
    chk("t3a_rx_ones", m.rx_data, 16'hFFFF);
    wait_ready("t3a_idle");
    miso_mode = 0;
    send(16'hFFFF, "t3b_ready");
    wait_rx("t3b_rx_seen");
    chk("t3b_rx_zeros", m.rx_data, 16'h0000);
    wait_ready("t3b_idle");

    // 4: back-to-back with tx_valid held, tx_data changed mid-frame
    miso_mode = 2;
    v0 = rxv;
    m.tx_data = 16'hFFFF;
    m.tx_valid = 1'b1;
    wait_ready("t4_ready1");
    @(negedge clk);
    repeat (20) @(negedge clk);
    m.tx_data = 16'h0000;
    wait_rx("t4_rx1_seen");
    chk("t4_rx1", m.rx_data, 16'hFFFF);
    @(negedge clk);
    chk("t4_mosi_cap1", mosi_cap, 16'hFFFF);
    wait_ready("t4_ready2");
    @(negedge clk);
    m.tx_valid = 1'b0;
    @(negedge clk);
    chk("t4_cs_gap", last_hi_run, 3);
    wait_rx("t4_rx2_seen");
    chk("t4_rx2", m.rx_data, 16'h0000);
    @(negedge clk);
    chk("t4_mosi_cap2", mosi_cap, 16'h0000);
    chk("t4_rxv_count", rxv - v0, 2);
    wait_ready("t4_idle");

    // 5: reset after the 7th sck rise, then a clean frame
    v0 = rxv; s0 = sl_rxv;
    m.tx_data = 16'h00FF;
    m.tx_valid = 1'b1;
    wait_ready("t5_ready");
    @(negedge clk);
    m.tx_valid = 1'b0;
    n = 0; sp = m.sck;
    for (int i = 0; i < 200 && n < 7; i++) begin
      @(negedge clk);
      if (m.sck === 1'b1 && sp === 1'b0) n++;
      sp = m.sck;
    end
    chk("t5_seven_rises", n, 7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_cs_n", m.cs_n, 1);
    chk("t5_sck", m.sck, 0);
    chk("t5_busy", m.busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_rx_valid", rxv - v0, 0);
    chk("t5_no_slave_rx", sl_rxv - s0, 0);
    send(16'h00FF, "t5_ready2");
    wait_rx("t5_rx_seen");
    chk("t5_rx_data", m.rx_data, 16'h00FF);
    wait_ready("t5_idle");

    // 6: CLK_DIV=4 instance, loopback
    r0 = rises4;
    m4.tx_data = 16'h3C5A;
    m4.tx_valid = 1'b1;
    for (int i = 0; i < 400 && m4.tx_ready !== 1'b1; i++) @(negedge clk);
    chk("t6_ready", m4.tx_ready, 1);
    @(negedge clk);
    m4.tx_valid = 1'b0;
    for (int i = 0; i < 600 && m4.rx_valid !== 1'b1; i++) @(negedge clk);
    chk("t6_rx_seen", m4.rx_valid, 1);
    chk("t6_rx_data", m4.rx_data, 16'h3C5A);
    @(negedge clk);
    chk("t6_rises", rises4 - r0, 16);
    chk("t6_cs_low", last_lo4_cs, 128);
    chk("t6_sck_high", last_shi4, 4);
    chk("t6_sck_low", last_slo4, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
